// File: rtl/mpt_plb.sv
// Multi-port Permission Lookaside Buffer: caches MPT leaf permissions per page, tagged by SDID.
// One-cycle registered lookups per port, single walker fill port, targeted flushes.
module mpt_plb #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned SDID_LEN    = 6,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned PAGE_SHIFT  = 12
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              lookup_valid_i,
    input  logic [NUM_PORTS*XLEN-1:0]         lookup_spa_i,
    input  logic [NUM_PORTS*SDID_LEN-1:0]     lookup_sdid_i,
    input  logic [NUM_PORTS*2-1:0]            lookup_access_i,
    output logic [NUM_PORTS-1:0]              lookup_rvalid_o,
    output logic [NUM_PORTS-1:0]              lookup_hit_o,
    output logic [NUM_PORTS-1:0]              lookup_allow_o,
    output logic [NUM_PORTS*3-1:0]            lookup_perms_o,
    input  logic                              fill_valid_i,
    input  logic [SDID_LEN-1:0]               fill_sdid_i,
    input  logic [XLEN-1:0]                   fill_spa_i,
    input  logic [2:0]                        fill_perms_i,
    input  logic                              flush_valid_i,
    input  logic [1:0]                        flush_mode_i,
    input  logic [SDID_LEN-1:0]               flush_sdid_i,
    input  logic [XLEN-1:0]                   flush_spa_i,
    output logic [$clog2(NUM_ENTRIES):0]      valid_count_o
);

    localparam int unsigned TAG_W = XLEN - PAGE_SHIFT;
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [1:0] FLUSH_ALL  = 2'd0;
    localparam logic [1:0] FLUSH_SDID = 2'd1;
    localparam logic [1:0] FLUSH_PAGE = 2'd2;
    localparam logic [1:0] FLUSH_NOP  = 2'd3;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } mpt_access_e;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
    logic [SDID_LEN-1:0]    sdid_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_d   [NUM_ENTRIES];
    logic [2:0]             perms_q [NUM_ENTRIES];
    logic [2:0]             perms_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       victim_q, victim_d;
    logic [CNT_W-1:0]       count_d;

    logic [TAG_W-1:0]       fill_tag, flush_tag;
    logic [NUM_ENTRIES-1:0] fill_match;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx, write_idx;
    logic                   flush_active;

    logic [NUM_PORTS-1:0]   hit_c, allow_c;
    logic [NUM_PORTS*3-1:0] perms_c;
    logic [SDID_LEN-1:0]    lk_sdid;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic [2:0]             lk_perms;
    logic                   unused_offsets;

    assign fill_tag       = fill_spa_i[XLEN-1:PAGE_SHIFT];
    assign flush_tag      = flush_spa_i[XLEN-1:PAGE_SHIFT];
    assign unused_offsets = ^{fill_spa_i[PAGE_SHIFT-1:0], flush_spa_i[PAGE_SHIFT-1:0]};

    // Next array state: a flush (other than the no-op mode) wins and drops a same-cycle fill
    always_comb begin
        valid_d      = valid_q;
        sdid_d       = sdid_q;
        tag_d        = tag_q;
        perms_d      = perms_q;
        victim_d     = victim_q;
        fill_match   = '0;
        free_found   = 1'b0;
        free_idx     = '0;
        write_idx    = '0;
        count_d      = '0;
        flush_active = flush_valid_i && (flush_mode_i != FLUSH_NOP);

        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            fill_match[i] = valid_q[i] && (sdid_q[i] == fill_sdid_i) && (tag_q[i] == fill_tag);
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        if (flush_active) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                case (flush_mode_i)
                    FLUSH_ALL:  valid_d[i] = 1'b0;
                    FLUSH_SDID: if (sdid_q[i] == flush_sdid_i) valid_d[i] = 1'b0;
                    FLUSH_PAGE: if ((sdid_q[i] == flush_sdid_i) && (tag_q[i] == flush_tag))
                                    valid_d[i] = 1'b0;
                    default:    ;
                endcase
            end
            if (flush_mode_i == FLUSH_ALL) victim_d = '0;
        end else if (fill_valid_i) begin
            if (|fill_match) begin
                for (int i = 0; i < int'(NUM_ENTRIES); i++)
                    if (fill_match[i]) perms_d[i] = fill_perms_i;
            end else begin
                write_idx = free_found ? free_idx : victim_q;
                if (!free_found) victim_d = victim_q + IDX_W'(1);
                for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                    if (IDX_W'(i) == write_idx) begin
                        valid_d[i] = 1'b1;
                        sdid_d[i]  = fill_sdid_i;
                        tag_d[i]   = fill_tag;
                        perms_d[i] = fill_perms_i;
                    end
                end
            end
        end

        for (int i = 0; i < int'(NUM_ENTRIES); i++)
            count_d = count_d + CNT_W'(valid_d[i]);
    end

    // Per-port lookup against pre-update contents; matches are OR-reduced
    always_comb begin
        hit_c    = '0;
        allow_c  = '0;
        perms_c  = '0;
        lk_sdid  = '0;
        lk_tag   = '0;
        lk_hit   = 1'b0;
        lk_perms = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            lk_sdid  = lookup_sdid_i[p*SDID_LEN +: SDID_LEN];
            lk_tag   = lookup_spa_i[p*XLEN+PAGE_SHIFT +: TAG_W];
            lk_hit   = 1'b0;
            lk_perms = '0;
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                if (valid_q[i] && (sdid_q[i] == lk_sdid) && (tag_q[i] == lk_tag)) begin
                    lk_hit   = 1'b1;
                    lk_perms = lk_perms | perms_q[i];
                end
            end
            if (lookup_valid_i[p] && lk_hit) begin
                hit_c[p]         = 1'b1;
                perms_c[p*3 +: 3] = lk_perms;
                case (lookup_access_i[p*2 +: 2])
                    ACC_READ:  allow_c[p] = lk_perms[0];
                    ACC_WRITE: allow_c[p] = lk_perms[1];
                    ACC_EXEC:  allow_c[p] = lk_perms[2];
                    default:   allow_c[p] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q         <= '0;
            victim_q        <= '0;
            valid_count_o   <= '0;
            lookup_rvalid_o <= '0;
            lookup_hit_o    <= '0;
            lookup_allow_o  <= '0;
            lookup_perms_o  <= '0;
        end else begin
            valid_q         <= valid_d;
            victim_q        <= victim_d;
            valid_count_o   <= count_d;
            lookup_rvalid_o <= lookup_valid_i;
            lookup_hit_o    <= hit_c;
            lookup_allow_o  <= allow_c;
            lookup_perms_o  <= perms_c;
        end
    end

    // Entry payloads are qualified by valid_q and need no reset
    always_ff @(posedge clk_i) begin
        sdid_q  <= sdid_d;
        tag_q   <= tag_d;
        perms_q <= perms_d;
    end

endmodule

// File: tb/tb_mpt_plb.sv
// Directed table-driven bench for mpt_plb (2 ports, 8 entries, XLEN 64).
module tb_mpt_plb;

    localparam logic [1:0] NO = 2'd0, RD = 2'd1, WR = 2'd2, EX = 2'd3;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   lookup_valid_i;
    logic [127:0] lookup_spa_i;
    logic [11:0]  lookup_sdid_i;
    logic [3:0]   lookup_access_i;
    logic [1:0]   lookup_rvalid_o, lookup_hit_o, lookup_allow_o;
    logic [5:0]   lookup_perms_o;
    logic         fill_valid_i;
    logic [5:0]   fill_sdid_i;
    logic [63:0]  fill_spa_i;
    logic [2:0]   fill_perms_i;
    logic         flush_valid_i;
    logic [1:0]   flush_mode_i;
    logic [5:0]   flush_sdid_i;
    logic [63:0]  flush_spa_i;
    logic [3:0]   valid_count_o;

    mpt_plb #(.XLEN(64), .SDID_LEN(6), .NUM_ENTRIES(8), .NUM_PORTS(2), .PAGE_SHIFT(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_valid_i(lookup_valid_i), .lookup_spa_i(lookup_spa_i),
        .lookup_sdid_i(lookup_sdid_i), .lookup_access_i(lookup_access_i),
        .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
        .lookup_allow_o(lookup_allow_o), .lookup_perms_o(lookup_perms_o),
        .fill_valid_i(fill_valid_i), .fill_sdid_i(fill_sdid_i),
        .fill_spa_i(fill_spa_i), .fill_perms_i(fill_perms_i),
        .flush_valid_i(flush_valid_i), .flush_mode_i(flush_mode_i),
        .flush_sdid_i(flush_sdid_i), .flush_spa_i(flush_spa_i),
        .valid_count_o(valid_count_o)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus plus expected responses {rvalid,hit,allow,perms} and count
    typedef struct packed {
        logic        fv;
        logic [5:0]  fsd;
        logic [63:0] fspa;
        logic [2:0]  fp;
        logic        xv;
        logic [1:0]  xm;
        logic [5:0]  xsd;
        logic [63:0] xspa;
        logic [1:0]  lv;
        logic [5:0]  lsd1, lsd0;
        logic [63:0] lspa1, lspa0;
        logic [1:0]  lacc1, lacc0;
        logic [5:0]  er1, er0;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t cur;
    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   nvec = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        cur = '0;
    endtask

    task automatic fl(input int sd, input logic [63:0] spa, input logic [2:0] p);
        cur.fv = 1'b1; cur.fsd = 6'(sd); cur.fspa = spa; cur.fp = p;
    endtask

    task automatic fx(input logic [1:0] m, input int sd, input logic [63:0] spa);
        cur.xv = 1'b1; cur.xm = m; cur.xsd = 6'(sd); cur.xspa = spa;
    endtask

    task automatic lk(input int port, input int sd, input logic [63:0] spa, input logic [1:0] acc);
        if (port == 0) begin
            cur.lv[0] = 1'b1; cur.lsd0 = 6'(sd); cur.lspa0 = spa; cur.lacc0 = acc; cur.er0 = 6'b100000;
        end else begin
            cur.lv[1] = 1'b1; cur.lsd1 = 6'(sd); cur.lspa1 = spa; cur.lacc1 = acc; cur.er1 = 6'b100000;
        end
    endtask

    task automatic ex(input int port, input logic h, input logic a, input logic [2:0] p);
        if (port == 0) cur.er0 = {1'b1, h, a, p};
        else           cur.er1 = {1'b1, h, a, p};
    endtask

    task automatic pu(input int n);
        cur.ecnt = 4'(n);
        vq.push_back(cur);
    endtask

    task automatic drive(input vec_t v);
        fill_valid_i    = v.fv;  fill_sdid_i  = v.fsd; fill_spa_i  = v.fspa; fill_perms_i = v.fp;
        flush_valid_i   = v.xv;  flush_mode_i = v.xm;  flush_sdid_i = v.xsd; flush_spa_i = v.xspa;
        lookup_valid_i  = v.lv;
        lookup_sdid_i   = {v.lsd1, v.lsd0};
        lookup_spa_i    = {v.lspa1, v.lspa0};
        lookup_access_i = {v.lacc1, v.lacc0};
    endtask

    task automatic run(input vec_t v);
        @(negedge clk_i);
        drive(v);
        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d_port0", nvec), 16'({lookup_rvalid_o[0], lookup_hit_o[0], lookup_allow_o[0], lookup_perms_o[2:0]}), 16'(v.er0));
        chk($sformatf("v%0d_port1", nvec), 16'({lookup_rvalid_o[1], lookup_hit_o[1], lookup_allow_o[1], lookup_perms_o[5:3]}), 16'(v.er1));
        chk($sformatf("v%0d_count", nvec), 16'(valid_count_o), 16'(v.ecnt));
        nvec++;
    endtask

    task automatic go(input int n);
        cur.ecnt = 4'(n);
        run(cur);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset miss, single fill, dual-port hit/allow, SDID mismatch
        clr(); lk(0, 3, 64'h8000_1234, RD); pu(0);
        clr(); fl(3, 64'h8000_1000, 3'b001); pu(1);
        clr(); lk(0, 3, 64'h8000_1FFC, RD); lk(1, 3, 64'h8000_1FFC, WR);
               ex(0, 1, 1, 3'b001); ex(1, 1, 0, 3'b001); pu(1);
        clr(); lk(0, 4, 64'h8000_1FFC, RD); lk(1, 4, 64'h8000_1FFC, WR); pu(1);
        clr(); lk(0, 3, 64'h8000_1FFC, EX); lk(1, 3, 64'h8000_1FFC, NO);
               ex(0, 1, 0, 3'b001); ex(1, 1, 0, 3'b001); pu(1);
        // Fill to capacity, then evict entry 0 while a lookup still sees it
        for (int k = 1; k <= 7; k++) begin
            clr(); fl(5, 64'(k) << 12, 3'b010); pu(1 + k);
        end
        clr(); fl(5, 64'h8000, 3'b100); lk(0, 3, 64'h8000_1000, RD); lk(1, 5, 64'h8000, EX);
               ex(0, 1, 1, 3'b001); pu(8);
        clr(); lk(0, 3, 64'h8000_1000, RD); lk(1, 5, 64'h8000, EX); ex(1, 1, 1, 3'b100); pu(8);
        clr(); fl(5, 64'h1000, 3'b111); pu(8);
        clr(); lk(0, 5, 64'h1000, EX); lk(1, 5, 64'h2000, WR);
               ex(0, 1, 1, 3'b111); ex(1, 1, 1, 3'b010); pu(8);
        // Victim pointer sits at 1 after the in-place update: entry 1 then entry 2 go next
        clr(); fl(5, 64'h9000, 3'b001); pu(8);
        clr(); lk(0, 5, 64'h1000, RD); lk(1, 5, 64'h9000, RD); ex(1, 1, 1, 3'b001); pu(8);
        clr(); fl(5, 64'hA000, 3'b001); pu(8);
        clr(); lk(0, 5, 64'h2000, WR); lk(1, 5, 64'h3000, WR); ex(1, 1, 1, 3'b010); pu(8);
        clr(); fx(2'd0, 0, 64'h0); lk(0, 5, 64'h3000, RD); ex(0, 1, 0, 3'b010); pu(0);
        clr(); lk(0, 5, 64'h3000, WR); lk(1, 5, 64'hA000, RD); pu(0);
        // Targeted flushes
        clr(); fl(1, 64'h1_0000, 3'b001); pu(1);
        clr(); fl(1, 64'h2_0000, 3'b011); pu(2);
        clr(); fl(2, 64'h1_0000, 3'b111); pu(3);
        clr(); fx(2'd2, 1, 64'h1_0000); lk(0, 1, 64'h1_0ABC, RD); ex(0, 1, 1, 3'b001); pu(2);
        clr(); lk(0, 1, 64'h1_0000, RD); lk(1, 2, 64'h1_0000, WR); ex(1, 1, 1, 3'b111); pu(2);
        clr(); lk(0, 1, 64'h2_0000, WR); ex(0, 1, 1, 3'b011); pu(2);
        clr(); fx(2'd1, 2, 64'h0); pu(1);
        clr(); lk(0, 2, 64'h1_0000, RD); lk(1, 1, 64'h2_0000, RD); ex(1, 1, 1, 3'b011); pu(1);
        clr(); fx(2'd3, 1, 64'h2_0000); lk(0, 1, 64'h2_0000, RD); ex(0, 1, 1, 3'b011); pu(1);
        clr(); fx(2'd3, 1, 64'h0); fl(1, 64'h3_0000, 3'b101); pu(2);
        clr(); lk(0, 1, 64'h3_0000, EX); lk(1, 1, 64'h2_0000, EX);
               ex(0, 1, 1, 3'b101); ex(1, 1, 0, 3'b011); pu(2);
        // Fill dropped when a flush lands in the same cycle
        clr(); fl(1, 64'h4_0000, 3'b111); fx(2'd1, 7, 64'h0); lk(0, 1, 64'h4_0000, RD); pu(2);
        clr(); lk(0, 1, 64'h4_0000, RD); pu(2);
        clr(); fx(2'd0, 0, 64'h0); fl(1, 64'h5_0000, 3'b111); pu(0);
        // Flush-all resets the victim pointer: 9th fill must evict entry 0
        for (int k = 0; k < 8; k++) begin
            clr(); fl(6, 64'h10_0000 + (64'(k) << 12), 3'b001); pu(k + 1);
        end
        clr(); fl(6, 64'h20_0000, 3'b010); pu(8);
        clr(); lk(0, 6, 64'h10_0000, RD); lk(1, 6, 64'h10_1000, RD); ex(1, 1, 1, 3'b001); pu(8);
        clr(); lk(0, 6, 64'h20_0000, WR); lk(1, 6, 64'h10_3000, RD);
               ex(0, 1, 1, 3'b010); ex(1, 1, 1, 3'b001); pu(8);

        clr();
        drive(cur);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outputs", {lookup_rvalid_o, lookup_hit_o, lookup_allow_o, lookup_perms_o, valid_count_o}, 16'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("post_reset_idle", {12'h0, lookup_rvalid_o, valid_count_o[1:0]}, 16'h0);
        chk("post_reset_count", 16'(valid_count_o), 16'h0);

        foreach (vq[i]) run(vq[i]);

        // Asynchronous reset mid-cycle with lookups pending
        clr(); fx(2'd0, 0, 64'h0); go(0);
        for (int k = 1; k <= 5; k++) begin
            clr(); fl(9, 64'(k) << 12, 3'b111); go(k);
        end
        clr(); lk(0, 9, 64'h1000, RD); lk(1, 9, 64'h5000, WR);
        ex(0, 1, 1, 3'b111); ex(1, 1, 1, 3'b111); go(5);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_outputs", {lookup_rvalid_o, lookup_hit_o, lookup_allow_o, lookup_perms_o, 4'h0}, 16'h0);
        chk("async_rst_count", 16'(valid_count_o), 16'h0);
        clr();
        drive(cur);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rvalid_after_release", 16'(lookup_rvalid_o), 16'h0);
        clr(); lk(0, 9, 64'h1000, RD); lk(1, 9, 64'h5000, WR); go(0);
        clr(); lk(0, 9, 64'h3000, EX); lk(1, 9, 64'h4000, RD); go(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
